// File: rtl/trisc_datapath_if.sv
// Strobe/program-load/status bundle between the TRISC controller (master) and datapath (slave).
interface trisc_datapath_if #(
    parameter int ADDR_W = 5,
    parameter int WORD_W = 8
);
    logic              C0, C1, C2, C3, C4, C5, C42, C6, C7, C8, C9, C10, C11;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [WORD_W-1:0] prog_data;
    logic              INCA, CLRA, LDA, STA, ADD, JMP;
    logic [ADDR_W-1:0] pc;
    logic [WORD_W-1:0] ir;
    logic [WORD_W-1:0] acc;
    logic              carry;
    logic              err;

    modport master (
        output C0, C1, C2, C3, C4, C5, C42, C6, C7, C8, C9, C10, C11,
        output prog_we, prog_addr, prog_data,
        input  INCA, CLRA, LDA, STA, ADD, JMP, pc, ir, acc, carry, err
    );

    modport slave (
        input  C0, C1, C2, C3, C4, C5, C42, C6, C7, C8, C9, C10, C11,
        input  prog_we, prog_addr, prog_data,
        output INCA, CLRA, LDA, STA, ADD, JMP, pc, ir, acc, carry, err
    );
endinterface

// File: rtl/trisc_datapath.sv
// TRISC datapath: PC/IR/MDR/ACC registers, unified RAM and opcode decode driven by controller strobes.
// Optional TRISC_STROBE_CHECK_EN adds a sticky illegal-strobe-combination flag on err.
module trisc_datapath #(
    parameter int OP_W   = 3,
    parameter int ADDR_W = 5,
    parameter int WORD_W = 8
) (
    input  logic           clk,
    input  logic           CLR,
    trisc_datapath_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] pc_q, addr;
    logic [WORD_W-1:0] ir_q, mdo_q, mdr_q, acc_q;
    logic              carry_q;
    logic [WORD_W:0]   sum;
    logic [OP_W-1:0]   opcode;

    assign addr   = bus.C3 ? ir_q[ADDR_W-1:0] : pc_q;
    assign sum    = {1'b0, acc_q} + {1'b0, mdr_q};
    assign opcode = ir_q[WORD_W-1:ADDR_W];

    // RAM has no reset; CLR only blocks writes. Program-load write is issued last so it wins a collision.
    always_ff @(posedge clk) begin
        if (!CLR) begin
            if (bus.C4 && bus.C5) mem[addr] <= acc_q;
            if (bus.prog_we)      mem[bus.prog_addr] <= bus.prog_data;
        end
    end

    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            mdo_q <= '0;
            mdr_q <= '0;
            ir_q  <= '0;
        end else begin
            if (bus.C4 && !bus.C5) mdo_q <= mem[addr];
            if (bus.C42)           mdr_q <= mdo_q;
            if (bus.C7)            ir_q  <= mdr_q;
        end
    end

    always_ff @(posedge clk or posedge CLR) begin
        if (CLR)         pc_q <= '0;
        else if (bus.C0) pc_q <= '0;
        else if (bus.C1) pc_q <= ir_q[ADDR_W-1:0];
        else if (bus.C2) pc_q <= pc_q + ADDR_W'(1);
    end

    // carry tracks only the ALU path; increment wraps without touching it.
    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            acc_q   <= '0;
            carry_q <= 1'b0;
        end else if (bus.C8) begin
            acc_q <= '0;
        end else if (bus.C9) begin
            acc_q <= acc_q + WORD_W'(1);
        end else if (bus.C11) begin
            if (bus.C10) {carry_q, acc_q} <= sum;
            else         acc_q <= mdr_q;
        end
    end

    always_comb begin
        bus.INCA = 1'b0;
        bus.CLRA = 1'b0;
        bus.LDA  = 1'b0;
        bus.STA  = 1'b0;
        bus.ADD  = 1'b0;
        bus.JMP  = 1'b0;
        case (opcode)
            OP_W'(1): bus.INCA = 1'b1;
            OP_W'(2): bus.CLRA = 1'b1;
            OP_W'(3): bus.LDA  = 1'b1;
            OP_W'(4): bus.STA  = 1'b1;
            OP_W'(5): bus.ADD  = 1'b1;
            OP_W'(6): bus.JMP  = 1'b1;
            default: ;
        endcase
    end

    assign bus.pc    = pc_q;
    assign bus.ir    = ir_q;
    assign bus.acc   = acc_q;
    assign bus.carry = carry_q;

`ifdef TRISC_STROBE_CHECK_EN
    logic illegal, err_q;

    // Last term: MDR capturing MDO on the same edge a read is refreshing it.
    assign illegal = (bus.C0 && bus.C1) || (bus.C0 && bus.C2) || (bus.C1 && bus.C2) ||
                     (bus.C8 && bus.C9) || (bus.C8 && bus.C11) || (bus.C9 && bus.C11) ||
                     (bus.C5 && !bus.C4) || (bus.C42 && bus.C4 && !bus.C5);

    always_ff @(posedge clk or posedge CLR) begin
        if (CLR)          err_q <= 1'b0;
        else if (illegal) err_q <= 1'b1;
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_trisc_datapath.sv
// Bench for trisc_datapath: fixed instruction-sequence table, hand corner sequences, random strobes vs model.
module tb_trisc_datapath;
    localparam int AW = 5;
    localparam int WW = 8;

    localparam logic [11:0] K0  = 12'h800, K1  = 12'h400, K2  = 12'h200, K3  = 12'h100;
    localparam logic [11:0] K4  = 12'h080, K5  = 12'h040, K42 = 12'h020, K7  = 12'h010;
    localparam logic [11:0] K8  = 12'h008, K9  = 12'h004, K10 = 12'h002, K11 = 12'h001;
    localparam logic [5:0]  D_INCA = 6'b100000, D_CLRA = 6'b010000, D_LDA = 6'b001000;
    localparam logic [5:0]  D_STA  = 6'b000100, D_ADD  = 6'b000010, D_JMP = 6'b000001;

`ifdef TRISC_STROBE_CHECK_EN
    localparam int ERR_EN = 1;
`else
    localparam int ERR_EN = 0;
`endif

    typedef struct {
        logic [11:0] s;
        logic [4:0]  pc;
        logic [7:0]  ir;
        logic [7:0]  acc;
        logic        carry;
        logic [5:0]  dec;
    } vec_t;

    logic clk = 1'b0;
    logic CLR;
    trisc_datapath_if #(.ADDR_W(AW), .WORD_W(WW)) bus ();

    trisc_datapath #(.OP_W(3), .ADDR_W(AW), .WORD_W(WW)) dut (
        .clk (clk),
        .CLR (CLR),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int m_pc, m_ir, m_mdo, m_mdr, m_acc, m_carry, m_err;
    int m_mem [32];
    vec_t tbl [$];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int dec_of(int ir);
        case (ir / 32)
            1: return 32;
            2: return 16;
            3: return 8;
            4: return 4;
            5: return 2;
            6: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic logic [5:0] dut_dec();
        return {bus.INCA, bus.CLRA, bus.LDA, bus.STA, bus.ADD, bus.JMP};
    endfunction

    // Reference: next state from the behavioural rules, all computed from pre-edge values.
    function automatic void model_step(logic [11:0] s, bit pwe, int pa, int pd, bit clr);
        bit c0 = s[11], c1 = s[10], c2 = s[9], c3 = s[8], c4 = s[7], c5 = s[6];
        bit c42 = s[5], c7 = s[4], c8 = s[3], c9 = s[2], c10 = s[1], c11 = s[0];
        int a, npc, nacc, ncarry, total;
        if (clr) begin
            m_pc = 0; m_ir = 0; m_mdo = 0; m_mdr = 0; m_acc = 0; m_carry = 0; m_err = 0;
            return;
        end
        a = c3 ? (m_ir % 32) : m_pc;
        npc = m_pc;
        if (c0)      npc = 0;
        else if (c1) npc = m_ir % 32;
        else if (c2) npc = (m_pc + 1) % 32;
        nacc = m_acc;
        ncarry = m_carry;
        total = m_acc + m_mdr;
        if (c8)       nacc = 0;
        else if (c9)  nacc = (m_acc + 1) % 256;
        else if (c11) begin
            if (c10) begin nacc = total % 256; ncarry = (total > 255) ? 1 : 0; end
            else     nacc = m_mdr;
        end
        if (ERR_EN != 0) begin
            if ((int'(c0) + int'(c1) + int'(c2)) > 1 || (int'(c8) + int'(c9) + int'(c11)) > 1 ||
                (c5 && !c4) || (c42 && c4 && !c5))
                m_err = 1;
        end
        if (c42) m_mdr = m_mdo;
        if (c7)  m_ir = m_mdr_old(m_ir, c7);
        if (c4 && !c5) m_mdo = m_mem[a];
        if (c4 && c5)  m_mem[a] = m_acc;
        if (pwe)       m_mem[pa] = pd;
        m_pc = npc;
        m_acc = nacc;
        m_carry = ncarry;
    endfunction

    // IR captures the MDR value that existed before this edge; held aside by the caller sequence.
    int mdr_before;
    function automatic int m_mdr_old(int cur_ir, bit c7);
        return c7 ? mdr_before : cur_ir;
    endfunction

    task automatic apply(logic [11:0] s, bit pwe, int pa, int pd, bit clr);
        {bus.C0, bus.C1, bus.C2, bus.C3, bus.C4, bus.C5, bus.C42,
         bus.C7, bus.C8, bus.C9, bus.C10, bus.C11} = s;
        bus.C6        = 1'($urandom % 2);
        bus.prog_we   = pwe;
        bus.prog_addr = 5'(pa);
        bus.prog_data = 8'(pd);
        CLR           = clr;
    endtask

    task automatic check_model();
        chk("pc", 32'(bus.pc), m_pc);
        chk("ir", 32'(bus.ir), m_ir);
        chk("acc", 32'(bus.acc), m_acc);
        chk("carry", 32'(bus.carry), m_carry);
        chk("decode", 32'(dut_dec()), dec_of(m_ir));
        chk("err", 32'(bus.err), m_err);
    endtask

    task automatic edge_and_check(logic [11:0] s, bit pwe, int pa, int pd, bit clr);
        @(posedge clk);
        mdr_before = m_mdr;
        model_step(s, pwe, pa, pd, clr);
        @(negedge clk);
        check_model();
    endtask

    task automatic drive(logic [11:0] s, bit pwe = 0, int pa = 0, int pd = 0, bit clr = 0);
        apply(s, pwe, pa, pd, clr);
        edge_and_check(s, pwe, pa, pd, clr);
    endtask

    function automatic vec_t mk(logic [11:0] s, int pc, int ir, int acc, int c, logic [5:0] dec);
        vec_t v;
        v.s = s; v.pc = 5'(pc); v.ir = 8'(ir); v.acc = 8'(acc); v.carry = 1'(c); v.dec = dec;
        return v;
    endfunction

    initial begin
        int img [32];
        apply(12'h000, 0, 0, 0, 1);
        m_pc = 0; m_ir = 0; m_mdo = 0; m_mdr = 0; m_acc = 0; m_carry = 0; m_err = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", {bus.pc, bus.ir, bus.acc, bus.carry, bus.err, dut_dec()}, 32'h0);

        // Program: LDA 26, LDA 27, ADD 28, INCA, STA 31, JMP 5
        for (int i = 0; i < 32; i++) img[i] = int'($urandom % 256);
        img[0] = 'h7A; img[1] = 'h7B; img[2] = 'hBC; img[3] = 'h20; img[4] = 'h9F; img[5] = 'hC5;
        img[26] = 'h5C; img[27] = 'hF0; img[28] = 'h20;
        for (int i = 0; i < 32; i++) drive(12'h000, 1, i, img[i]);

        tbl.push_back(mk(K4,       0, 'h00, 'h00, 0, 6'd0));
        tbl.push_back(mk(K42,      0, 'h00, 'h00, 0, 6'd0));
        tbl.push_back(mk(K2 | K7,  1, 'h7A, 'h00, 0, D_LDA));
        tbl.push_back(mk(K3 | K4,  1, 'h7A, 'h00, 0, D_LDA));
        tbl.push_back(mk(K42,      1, 'h7A, 'h00, 0, D_LDA));
        tbl.push_back(mk(K11,      1, 'h7A, 'h5C, 0, D_LDA));
        tbl.push_back(mk(K4,       1, 'h7A, 'h5C, 0, D_LDA));
        tbl.push_back(mk(K42,      1, 'h7A, 'h5C, 0, D_LDA));
        tbl.push_back(mk(K2 | K7,  2, 'h7B, 'h5C, 0, D_LDA));
        tbl.push_back(mk(K3 | K4,  2, 'h7B, 'h5C, 0, D_LDA));
        tbl.push_back(mk(K42,      2, 'h7B, 'h5C, 0, D_LDA));
        tbl.push_back(mk(K11,      2, 'h7B, 'hF0, 0, D_LDA));
        tbl.push_back(mk(K4,       2, 'h7B, 'hF0, 0, D_LDA));
        tbl.push_back(mk(K42,      2, 'h7B, 'hF0, 0, D_LDA));
        tbl.push_back(mk(K2 | K7,  3, 'hBC, 'hF0, 0, D_ADD));
        tbl.push_back(mk(K3 | K4,  3, 'hBC, 'hF0, 0, D_ADD));
        tbl.push_back(mk(K42,      3, 'hBC, 'hF0, 0, D_ADD));
        tbl.push_back(mk(K10 | K11, 3, 'hBC, 'h10, 1, D_ADD));
        tbl.push_back(mk(K4,       3, 'hBC, 'h10, 1, D_ADD));
        tbl.push_back(mk(K42,      3, 'hBC, 'h10, 1, D_ADD));
        tbl.push_back(mk(K2 | K7,  4, 'h20, 'h10, 1, D_INCA));
        tbl.push_back(mk(K9,       4, 'h20, 'h11, 1, D_INCA));
        tbl.push_back(mk(K4,       4, 'h20, 'h11, 1, D_INCA));
        tbl.push_back(mk(K42,      4, 'h20, 'h11, 1, D_INCA));
        tbl.push_back(mk(K2 | K7,  5, 'h9F, 'h11, 1, D_STA));
        tbl.push_back(mk(K3 | K4 | K5, 5, 'h9F, 'h11, 1, D_STA));
        tbl.push_back(mk(K4,       5, 'h9F, 'h11, 1, D_STA));
        tbl.push_back(mk(K42,      5, 'h9F, 'h11, 1, D_STA));
        tbl.push_back(mk(K2 | K7,  6, 'hC5, 'h11, 1, D_JMP));
        tbl.push_back(mk(K1,       5, 'hC5, 'h11, 1, D_JMP));

        foreach (tbl[i]) begin
            drive(tbl[i].s);
            chk($sformatf("tbl[%0d]", i), {bus.pc, bus.ir, bus.acc, bus.carry, dut_dec()},
                {tbl[i].pc, tbl[i].ir, tbl[i].acc, tbl[i].carry, tbl[i].dec});
        end

        // STA result read back through PC path; PC wraps 31 -> 0
        drive(K0);
        repeat (31) drive(K2);
        chk("pc_31", 32'(bus.pc), 31);
        drive(K4); drive(K42); drive(K11);
        chk("sta_mem31", 32'(bus.acc), 'h11);
        drive(K2);
        chk("pc_wrap", 32'(bus.pc), 0);

        // ACC wrap and strobe priority
        drive(K8);
        repeat (255) drive(K9);
        chk("acc_ff", 32'(bus.acc), 'hFF);
        drive(K9);
        chk("inca_wrap", {bus.acc, bus.carry}, {8'h00, 1'b1});
        drive(K9);
        drive(K8 | K9 | K11);
        chk("acc_prio", 32'(bus.acc), 0);
        drive(K2); drive(K2);
        drive(K0 | K2);
        chk("pc_prio", 32'(bus.pc), 0);

        // Unassigned opcodes decode to nothing
        drive(12'h000, 1, 0, 'hE0);
        drive(K0); drive(K4); drive(K42); drive(K7);
        chk("dec_111", {bus.ir, 2'b00, dut_dec()}, {8'hE0, 8'h00});
        drive(12'h000, 1, 0, 'h07);
        drive(K4); drive(K42); drive(K7);
        chk("dec_000", {bus.ir, 2'b00, dut_dec()}, {8'h07, 8'h00});

        // Asynchronous CLR mid-cycle with a RAM write pending; RAM must survive
        drive(K9); drive(K2);
        apply(K4 | K5, 0, 0, 0, 1);
        #1;
        chk("clr_async", {bus.pc, bus.ir, bus.acc, bus.carry, bus.err}, 32'h0);
        edge_and_check(K4 | K5, 0, 0, 0, 1);
        drive(K4); drive(K42); drive(K7);
        chk("ram_intact", 32'(bus.ir), 'h07);

        // Sticky illegal-strobe flag
        drive(K8 | K9);
        chk("err_set", 32'(bus.err), ERR_EN);
        drive(12'h000);
        chk("err_hold", 32'(bus.err), ERR_EN);
        drive(12'h000, 0, 0, 0, 1);
        chk("err_clr", 32'(bus.err), 0);

        // Random strobes, program writes and resets against the model
        for (int n = 0; n < 3000; n++) begin
            logic [11:0] s;
            s = 12'($urandom);
            drive(s, ($urandom % 6) == 0, int'($urandom % 32), int'($urandom % 256),
                  ($urandom % 80) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
